// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of fetch-time branch predictions, resolved by EX
// into registered predictor-update and mispredict/redirect pulses.
module branch_resolve_queue #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 8,
    parameter int PC_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_pc,
    input  logic                     push_pred,
    input  logic [PC_W-1:0]          push_target,
    output logic                     push_ready,
    input  logic                     resolve,
    input  logic                     resolve_taken,
    input  logic [PC_W-1:0]          resolve_target,
    input  logic [6:0]               resolve_opcode,
    input  logic                     flush,
    output logic                     update,
    output logic [ADDR_BITS-1:0]     update_address,
    output logic                     branch_taken,
    output logic [6:0]               EX_MEM_opcode,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic [PC_W-1:0] tgt_mem [DEPTH];
    logic            pred_mem[DEPTH];

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          update_q, mispredict_q, branch_taken_q, overflow_q, underflow_q;
    logic [ADDR_BITS-1:0] update_address_q;
    logic [6:0]    opcode_q;
    logic [PC_W-1:0] redirect_q;

    logic full, empty, res_ok, wrong, mis_now, push_ok, clear;
    logic [PC_W-1:0] h_pc, h_tgt, correct_pc;
    logic h_pred;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign res_ok  = resolve && !empty;
    assign h_pc    = pc_mem[rd_q];
    assign h_tgt   = tgt_mem[rd_q];
    assign h_pred  = pred_mem[rd_q];
    assign wrong   = (resolve_taken != h_pred) || (resolve_taken && resolve_target != h_tgt);
    assign mis_now = res_ok && wrong;
    // A mispredict makes every younger entry wrong-path, so it also kills a same-cycle push.
    assign push_ok = push && !full && !flush && !mis_now;
    assign clear   = flush || mis_now;
    assign correct_pc = resolve_taken ? resolve_target : h_pc + PC_W'(4);

    always_comb begin
        rd_d    = clear ? '0 : rd_q + AW'(res_ok);
        wr_d    = clear ? '0 : wr_q + AW'(push_ok);
        count_d = clear ? '0 : count_q + CW'(push_ok) - CW'(res_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_q]   <= push_pc;
            tgt_mem[wr_q]  <= push_target;
            pred_mem[wr_q] <= push_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q             <= '0;
            wr_q             <= '0;
            count_q          <= '0;
            update_q         <= 1'b0;
            mispredict_q     <= 1'b0;
            branch_taken_q   <= 1'b0;
            update_address_q <= '0;
            opcode_q         <= '0;
            redirect_q       <= '0;
            overflow_q       <= 1'b0;
            underflow_q      <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            count_q      <= count_d;
            update_q     <= res_ok && resolve_opcode == OP_BRANCH;
            mispredict_q <= mis_now;
            overflow_q   <= overflow_q | (push && full);
            underflow_q  <= underflow_q | (resolve && empty);
            if (res_ok) begin
                branch_taken_q   <= resolve_taken;
                update_address_q <= h_pc[ADDR_BITS+1:2];
                opcode_q         <= resolve_opcode;
                redirect_q       <= correct_pc;
            end
        end
    end

    assign push_ready     = !full;
    assign count          = count_q;
    assign update         = update_q;
    assign mispredict     = mispredict_q;
    assign branch_taken   = branch_taken_q;
    assign update_address = update_address_q;
    assign EX_MEM_opcode  = opcode_q;
    assign redirect_pc    = redirect_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scenarios plus random traffic checked against a
// queue-based model of the branch resolve FIFO.
module tb_branch_resolve_queue;
    logic clk = 0, rst = 1;
    logic push = 0, push_pred = 0, resolve = 0, resolve_taken = 0, flush = 0;
    logic [31:0] push_pc = 0, push_target = 0, resolve_target = 0, redirect_pc;
    logic [6:0] resolve_opcode = 0, EX_MEM_opcode;
    logic push_ready, update, branch_taken, mispredict, overflow, underflow;
    logic [7:0] update_address;
    logic [2:0] count;

    branch_resolve_queue dut (
        .clk(clk), .rst(rst), .push(push), .push_pc(push_pc), .push_pred(push_pred),
        .push_target(push_target), .push_ready(push_ready), .resolve(resolve),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_opcode(resolve_opcode), .flush(flush), .update(update),
        .update_address(update_address), .branch_taken(branch_taken),
        .EX_MEM_opcode(EX_MEM_opcode), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic pred; logic [31:0] tgt; } ent_t;
    ent_t q[$];
    logic m_ovf, m_unf, m_upd, m_mis, m_bt;
    logic [7:0] m_addr;
    logic [6:0] m_op;
    logic [31:0] m_rpc;
    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        {m_ovf, m_unf, m_upd, m_mis, m_bt} = '0;
        m_addr = 0; m_op = 0; m_rpc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_update"}, update, m_upd);
        check({tag, "_mispredict"}, mispredict, m_mis);
        check({tag, "_count"}, count, q.size());
        check({tag, "_overflow"}, overflow, m_ovf);
        check({tag, "_underflow"}, underflow, m_unf);
        check({tag, "_taken"}, branch_taken, m_bt);
        check({tag, "_addr"}, update_address, m_addr);
        check({tag, "_opcode"}, EX_MEM_opcode, m_op);
        check({tag, "_redirect"}, redirect_pc, m_rpc);
    endtask

    task automatic cyc(input string tag, input logic p, input logic [31:0] pc, input logic pr,
                       input logic [31:0] tg, input logic r, input logic rt,
                       input logic [31:0] rtg, input logic [6:0] op, input logic f);
        ent_t e;
        logic was_full, wrong;
        push = p; push_pc = pc; push_pred = pr; push_target = tg;
        resolve = r; resolve_taken = rt; resolve_target = rtg; resolve_opcode = op; flush = f;
        #1;
        check({tag, "_push_ready"}, push_ready, q.size() != 4);
        was_full = q.size() == 4;
        wrong = 0;
        m_upd = 0; m_mis = 0;
        if (p && was_full) m_ovf = 1;
        if (r && q.size() == 0) m_unf = 1;
        if (r && q.size() > 0) begin
            e = q.pop_front();
            wrong = (rt != e.pred) || (rt && rtg != e.tgt);
            m_upd = op == 7'h63;
            m_mis = wrong;
            m_bt = rt;
            m_addr = e.pc[9:2];
            m_op = op;
            m_rpc = rt ? rtg : e.pc + 32'd4;
        end
        if (p && !was_full && !f && !wrong) q.push_back('{pc, pr, tg});
        if (f || wrong) q.delete();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_push(input string tag, input logic [31:0] pc, input logic pr, input logic [31:0] tg);
        cyc(tag, 1, pc, pr, tg, 0, 0, 0, 0, 0);
    endtask

    task automatic do_res(input string tag, input logic rt, input logic [31:0] rtg, input logic [6:0] op);
        cyc(tag, 0, 0, 0, 0, 1, rt, rtg, op, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_push_ready", push_ready, 1);
        check_all("rst");
        @(negedge clk);
        rst = 0;

        do_push("tp1_push", 32'h100, 0, 32'h120);
        do_res("tp1_res", 1, 32'h120, 7'h63);
        check("tp1_addr40", update_address, 8'h40);
        check("tp1_redirect", redirect_pc, 32'h120);
        check("tp1_mis", mispredict, 1);

        for (int i = 0; i < 4; i++) do_push("tp2_push", 32'(i * 4), 0, 32'h0);
        check("tp2_full_ready", push_ready, 0);
        do_push("tp2_over", 32'h10, 0, 32'h0);
        check("tp2_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            do_res("tp2_res", 0, 32'h0, 7'h63);
            check("tp2_addr_order", update_address, i);
        end
        check("tp2_empty", count, 0);

        do_push("tp3_push", 32'h200, 1, 32'h300);
        do_res("tp3_res", 1, 32'h304, 7'h67);
        check("tp3_no_update", update, 0);
        check("tp3_redirect", redirect_pc, 32'h304);

        for (int i = 0; i < 3; i++) do_push("tp4_push", 32'h400 + 32'(i * 4), 0, 32'h0);
        cyc("tp4_mis", 1, 32'h500, 0, 0, 1, 1, 32'h440, 7'h63, 0);
        check("tp4_cleared", count, 0);
        do_res("tp4_under", 0, 0, 7'h63);
        check("tp4_underflow", underflow, 1);

        do_push("tp5_fill", 32'h1000, 0, 0);
        do_push("tp5_fill", 32'h1004, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc("tp5_pair", 1, 32'h1008 + 32'(i * 4), 0, 0, 1, 0, 0, 7'h63, 0);
            check("tp5_addr", update_address, 8'(('h1000 + i * 4) >> 2));
        end
        check("tp5_count2", count, 2);
        cyc("flush", 0, 0, 0, 0, 1, 0, 0, 7'h63, 1);

        for (int i = 0; i < 400; i++) begin
            logic p, r, f, rt;
            logic [31:0] rtg;
            logic [6:0] op;
            p = 1'($urandom);
            r = 1'($urandom);
            f = ($urandom % 16) == 0;
            op = ($urandom % 3 == 0) ? (($urandom % 2) ? 7'h6f : 7'h67) : 7'h63;
            rt = 1'($urandom);
            rtg = $urandom & ~32'h3;
            if (q.size() > 0 && $urandom % 5 != 0) begin
                rt = q[0].pred;
                if (rt) rtg = q[0].tgt;
            end
            cyc("rand", p, $urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3, r, rt, rtg, op, f);
        end

        for (int i = 0; i < 3; i++) do_push("tp6_fill", 32'h800 + 32'(i * 4), 0, 0);
        resolve = 1; resolve_taken = 1; resolve_target = 32'h900; resolve_opcode = 7'h63; push = 0; flush = 0;
        #1 rst = 1;
        #1;
        model_reset();
        check("tp6_ready", push_ready, 1);
        check_all("tp6_async");
        @(posedge clk);
        #1;
        check_all("tp6_held");
        @(negedge clk);
        rst = 0;
        cyc("tp6_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every control-flow instruction from the cycle the fetch stage issues its prediction until the EX stage resolves it. Compares the actual outcome with the stored prediction and produces the one-cycle update strobe, index and outcome that drive the gshare predictor's update port. Also produces the mispredict/redirect request to fetch. It sits between IF (push side) and EX/MEM (resolve side) and is implemented as an in-order FIFO.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- ADDR_BITS, 8: width of update_address
- PC_W, 32: PC width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- push  in  PC_W-free 1  IF issued a branch/JAL/JALR with a prediction
- push_pc  in  PC_W  PC of that instruction
- push_pred  in  1  predicted taken
- push_target  in  PC_W  predicted target
- push_ready  out  1  combinational: count != DEPTH
- resolve  in  1  EX resolves the oldest entry
- resolve_taken  in  1  actual direction (1 for JAL/JALR)
- resolve_target  in  PC_W  actual target
- resolve_opcode  in  7  opcode of resolving instruction
- flush  in  1  external pipeline flush (trap etc.)
- update  out  1  registered pulse: train predictor
- update_address  out  ADDR_BITS  stored push_pc[ADDR_BITS+1:2]
- branch_taken  out  1  actual direction for predictor
- EX_MEM_opcode  out  7  registered resolve_opcode
- mispredict  out  1  registered pulse
- redirect_pc  out  PC_W  correct next PC, valid with mispredict
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: push seen while full
- underflow  out  1  sticky: resolve seen while empty

## Operation
- Storage per entry: pc, pred, target. Read pointer rd and write pointer wr are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- Push is accepted when push && count != DEPTH && !flush && !mispredict_now. It writes the entry at wr, then wr+1.
- Push while full is dropped and sets overflow. It is dropped even if resolve is asserted in the same cycle.
- Resolve with count != 0 pops the entry at rd and evaluates:
  - wrong = (resolve_taken != pred) || (resolve_taken && resolve_target != target)
  - correct PC = resolve_taken ? resolve_target : pc+4 (mod 2^PC_W)
- Resolve with count == 0 sets underflow. No output pulses are produced and the pointers do not change.
- update fires only when resolve_opcode == 7'b1100011 (conditional branch). JAL/JALR never train the BHT, but they are checked for mispredict (JALR target).
- mispredict_now = a valid resolve with wrong asserted. On it, the whole queue is cleared (rd=wr=0, count=0) because all younger entries are wrong-path, and any same-cycle push is discarded.
- flush clears the queue the same way. A resolve in the same cycle as flush is still evaluated and reported; the flush only removes the remaining entries.
- Simultaneous push and correct resolve with 0<count<DEPTH: count is unchanged and both pointers advance.
- overflow and underflow clear only on rst.

## Timing
- Reset (asynchronous, immediate): update=0, mispredict=0, branch_taken=0, update_address=0, EX_MEM_opcode=0, redirect_pc=0, count=0, overflow=0, underflow=0, pointers=0, push_ready=1.
- update, branch_taken, update_address, EX_MEM_opcode, mispredict and redirect_pc are registered. They become valid on the edge after the resolve cycle.
- update and mispredict are high for exactly one cycle per resolve. They are 0 in all other cycles.
- Data outputs hold their last value between pulses.
- A push in cycle N is resolvable in cycle N+1 at the earliest.
- After a mispredict or flush edge, push_ready=1 and count=0 in the following cycle.
- rst asserted mid-operation discards all entries and any pulse pending that cycle.

## Test plan
- Push pc=0x100, pred=0, target=0x120; resolve taken, target 0x120, opcode 1100011 -> next cycle: update=1, update_address=0x40, branch_taken=1, mispredict=1, redirect_pc=0x120, count=0.
- Push 4 correctly predicted not-taken branches (pc 0x0,0x4,0x8,0xC); 5th push -> push_ready=0, overflow=1. Then 4 resolves not-taken -> four update pulses with addresses 0,1,2,3, no mispredict, count back to 0.
- JALR pc=0x200, pred=1, target=0x300; resolve taken, target 0x304, opcode 1100111 -> update=0, mispredict=1, redirect_pc=0x304.
- Fill to 3; resolve oldest as mispredict while pushing in the same cycle -> count=0, the push is discarded, and the next resolve sets underflow=1.
- Wrap test: 10 push/resolve pairs with push and resolve in the same cycle at count=2 -> count stays 2, and update_address matches FIFO order across pointer wrap.
- Assert rst mid-stream with count=3 and a resolve pending -> all outputs are 0 immediately, no update pulse, push_ready=1.
